// File: rtl/clap_detector.sv
`default_nettype none
// ============================================================================
//  Module      : clap_detector
//  Description : Turns a signed microphone sample stream into the clap_set
//                level for the mode controller. A clap is a run of at least
//                MIN_LEN loud samples closed by QUIET_LEN quiet samples.
//                CLAP_COUNT claps, each registered within WINDOW samples of
//                the previous one, raise clap_set_o for HOLD_CYCLES clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module clap_detector #(
  parameter int SAMPLE_W    = 12,
  parameter int THRESHOLD   = 1500,
  parameter int MIN_LEN     = 4,
  parameter int QUIET_LEN   = 64,
  parameter int WINDOW      = 4000,
  parameter int CLAP_COUNT  = 2,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                sample_valid_i,
  output logic                clap_set_o,
  output logic [2:0]          state_o,
  output logic [2:0]          clap_cnt_o
);

  localparam int LW = $clog2(MIN_LEN + 1);
  localparam int QW = $clog2(QUIET_LEN + 1);
  localparam int GW = $clog2(WINDOW + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [SAMPLE_W-2:0] c_THRESHOLD  = (SAMPLE_W-1)'(THRESHOLD);
  localparam logic [LW-1:0]       c_MIN_LEN    = LW'(MIN_LEN);
  localparam logic [LW-1:0]       c_L_ONE      = LW'(1);
  localparam logic [QW-1:0]       c_QUIET_LEN  = QW'(QUIET_LEN);
  localparam logic [QW-1:0]       c_Q_ONE      = QW'(1);
  localparam logic [GW-1:0]       c_WINDOW     = GW'(WINDOW);
  localparam logic [GW-1:0]       c_G_ONE      = GW'(1);
  localparam logic [HW-1:0]       c_HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]       c_H_ONE      = HW'(1);
  localparam logic [2:0]          c_CLAP_COUNT = 3'(CLAP_COUNT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOUD  = 3'd1,
    S_QUIET = 3'd2,
    S_WAIT  = 3'd3,
    S_FIRE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   loud_cnt_q, loud_cnt_d;
  logic [QW-1:0]   quiet_cnt_q, quiet_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [2:0]      clap_cnt_q, clap_cnt_d;
  logic            clap_set_q, clap_set_d;

  logic [SAMPLE_W-1:0] mag_full;
  logic [SAMPLE_W-2:0] mag;
  logic                loud;
  logic                tracking;
  logic                timeout;
  logic                close_clap;
  logic [2:0]          cnt_at_close;

  // Magnitude of the sample; the most negative code saturates to full scale.
  always_comb begin
    mag_full = sample_i[SAMPLE_W-1] ? -sample_i : sample_i;
    mag      = mag_full[SAMPLE_W-1] ? '1 : mag_full[SAMPLE_W-2:0];
    loud     = (mag >= c_THRESHOLD);
  end

  // Next-state logic: clap qualification, gap window, refractory and hold.
  always_comb begin
    state_d      = state_q;
    loud_cnt_d   = loud_cnt_q;
    quiet_cnt_d  = quiet_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    clap_cnt_d   = clap_cnt_q;
    close_clap   = 1'b0;
    cnt_at_close = clap_cnt_q;

    // The gap window only runs while a sequence is in progress.
    tracking = (clap_cnt_q != 3'd0) &&
               ((state_q == S_LOUD) || (state_q == S_QUIET) || (state_q == S_WAIT));
    // Once the last clap is in, the sequence can no longer time out.
    timeout  = tracking && (clap_cnt_q < c_CLAP_COUNT) && (gap_cnt_q == c_WINDOW);

    if (tracking && sample_valid_i && (gap_cnt_q != c_WINDOW)) begin
      gap_cnt_d = gap_cnt_q + c_G_ONE;
    end

    if (timeout) begin
      // Sequence abandoned; the sample in this cycle is dropped.
      state_d     = S_IDLE;
      clap_cnt_d  = 3'd0;
      gap_cnt_d   = '0;
      loud_cnt_d  = '0;
      quiet_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_WAIT: begin
          if (sample_valid_i && loud) begin
            state_d    = S_LOUD;
            loud_cnt_d = c_L_ONE;
          end
        end
        S_LOUD: begin
          if (sample_valid_i) begin
            if (loud) begin
              if (loud_cnt_q != c_MIN_LEN) begin
                loud_cnt_d = loud_cnt_q + c_L_ONE;
              end
            end else if (loud_cnt_q == c_MIN_LEN) begin
              // Burst long enough: register the clap and start its quiet tail.
              clap_cnt_d   = clap_cnt_q + 3'd1;
              cnt_at_close = clap_cnt_q + 3'd1;
              gap_cnt_d    = '0;
              loud_cnt_d   = '0;
              quiet_cnt_d  = c_Q_ONE;
              state_d      = S_QUIET;
              close_clap   = (c_Q_ONE == c_QUIET_LEN);
            end else begin
              // Too short to be a clap; drop the burst.
              loud_cnt_d = '0;
              state_d    = (clap_cnt_q != 3'd0) ? S_WAIT : S_IDLE;
            end
          end
        end
        S_QUIET: begin
          if (sample_valid_i) begin
            if (loud) begin
              // Ringing tail of the same clap restarts the quiet run.
              quiet_cnt_d = '0;
            end else begin
              quiet_cnt_d = quiet_cnt_q + c_Q_ONE;
              close_clap  = ((quiet_cnt_q + c_Q_ONE) == c_QUIET_LEN);
            end
          end
        end
        S_FIRE: begin
          if (hold_cnt_q == c_HOLD_LAST) begin
            state_d    = S_IDLE;
            hold_cnt_d = '0;
            clap_cnt_d = 3'd0;
            gap_cnt_d  = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + c_H_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (close_clap) begin
        quiet_cnt_d = '0;
        if (cnt_at_close == c_CLAP_COUNT) begin
          state_d    = S_FIRE;
          hold_cnt_d = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
    end

    // Level is high exactly while the FSM sits in FIRE.
    clap_set_d = (state_d == S_FIRE);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      loud_cnt_q  <= '0;
      quiet_cnt_q <= '0;
      gap_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      clap_cnt_q  <= 3'd0;
      clap_set_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      loud_cnt_q  <= loud_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      clap_cnt_q  <= clap_cnt_d;
      clap_set_q  <= clap_set_d;
    end
  end

  assign clap_set_o = clap_set_q;
  assign state_o    = state_q;
  assign clap_cnt_o = clap_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_clap_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clap_detector
//  Description : Directed self-checking bench for clap_detector
//                (THRESHOLD=100 MIN_LEN=2 QUIET_LEN=3 WINDOW=20
//                 CLAP_COUNT=2 HOLD_CYCLES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clap_detector;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [11:0] sample_i;
  logic        sample_valid_i;
  logic        clap_set_o;
  logic [2:0]  state_o;
  logic [2:0]  clap_cnt_o;

  int vectors     = 0;
  int miscompares = 0;

  localparam int ST_IDLE  = 0;
  localparam int ST_LOUD  = 1;
  localparam int ST_QUIET = 2;
  localparam int ST_WAIT  = 3;
  localparam int ST_FIRE  = 4;

  int seq1 [11] = '{200, 200, 0, 0, 0, 5, 200, 200, 0, 0, 0};

  always #5 clk_i = ~clk_i;

  clap_detector #(
    .SAMPLE_W   (12),
    .THRESHOLD  (100),
    .MIN_LEN    (2),
    .QUIET_LEN  (3),
    .WINDOW     (20),
    .CLAP_COUNT (2),
    .HOLD_CYCLES(4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .sample_i      (sample_i),
    .sample_valid_i(sample_valid_i),
    .clap_set_o    (clap_set_o),
    .state_o       (state_o),
    .clap_cnt_o    (clap_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one input for one clock, then settle just after the edge.
  task automatic send(input int v, input bit vld);
    sample_i       = 12'(v);
    sample_valid_i = vld;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    send(0, 1'b0);
    send(0, 1'b0);
    rst_i = 1'b0;
  endtask

  // Count clap_set_o high cycles starting at the current cycle.
  task automatic count_hold(input bit toggle, output int hi);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (clap_set_o) hi++;
      send(0, toggle ? bit'(i % 2) : 1'b1);
    end
  endtask

  initial begin
    int hi;
    int seen_hi;
    int max_st;
    int cnt_seen;

    rst_i          = 1'b1;
    sample_i       = '0;
    sample_valid_i = 1'b0;
    do_reset();
    check("reset_state", state_o, ST_IDLE);
    check("reset_clap_cnt", clap_cnt_o, 0);
    check("reset_clap_set", clap_set_o, 0);

    // Test 1: double clap fires
    send(200, 1'b1);
    check("t1_loud", state_o, ST_LOUD);
    send(200, 1'b1);
    send(0, 1'b1);
    check("t1_reg1_cnt", clap_cnt_o, 1);
    check("t1_reg1_state", state_o, ST_QUIET);
    send(0, 1'b1);
    send(0, 1'b1);
    check("t1_wait", state_o, ST_WAIT);
    send(5, 1'b1);
    check("t1_wait_quiet", state_o, ST_WAIT);
    send(200, 1'b1);
    send(200, 1'b1);
    send(0, 1'b1);
    check("t1_reg2_cnt", clap_cnt_o, 2);
    send(0, 1'b1);
    check("t1_pre_fire_set", clap_set_o, 0);
    send(0, 1'b1);
    check("t1_fire_state", state_o, ST_FIRE);
    check("t1_fire_set", clap_set_o, 1);
    count_hold(1'b0, hi);
    check("t1_hold_len", hi, 4);
    check("t1_end_state", state_o, ST_IDLE);
    check("t1_end_cnt", clap_cnt_o, 0);

    // Test 2: single clap times out
    do_reset();
    seen_hi = 0;
    send(200, 1'b1);
    send(200, 1'b1);
    send(0, 1'b1);
    check("t2_reg_cnt", clap_cnt_o, 1);
    for (int i = 0; i < 19; i++) begin
      send(0, 1'b1);
      if (clap_set_o) seen_hi++;
    end
    check("t2_before_timeout_cnt", clap_cnt_o, 1);
    check("t2_before_timeout_state", state_o, ST_WAIT);
    send(0, 1'b1);
    if (clap_set_o) seen_hi++;
    send(0, 1'b1);
    if (clap_set_o) seen_hi++;
    check("t2_timeout_state", state_o, ST_IDLE);
    check("t2_timeout_cnt", clap_cnt_o, 0);
    check("t2_never_set", seen_hi, 0);

    // Test 3: one-sample glitches never count
    do_reset();
    max_st   = 0;
    cnt_seen = 0;
    for (int i = 0; i < 6; i++) begin
      send(200, 1'b1);
      if (int'(state_o) > max_st) max_st = int'(state_o);
      if (clap_cnt_o != 3'd0) cnt_seen++;
      send(0, 1'b1);
      if (int'(state_o) > max_st) max_st = int'(state_o);
      if (clap_cnt_o != 3'd0) cnt_seen++;
    end
    check("t3_max_state", max_st, ST_LOUD);
    check("t3_cnt_zero", cnt_seen, 0);
    check("t3_end_state", state_o, ST_IDLE);

    // Test 4: negative burst with loud tail during the quiet run
    do_reset();
    send(-2048, 1'b1);
    check("t4_min_code_loud", state_o, ST_LOUD);
    send(-150, 1'b1);
    send(0, 1'b1);
    check("t4_reg_cnt", clap_cnt_o, 1);
    send(300, 1'b1);
    check("t4_tail_state", state_o, ST_QUIET);
    send(0, 1'b1);
    send(0, 1'b1);
    check("t4_restarted_quiet", state_o, ST_QUIET);
    send(0, 1'b1);
    check("t4_closed_state", state_o, ST_WAIT);
    check("t4_one_clap", clap_cnt_o, 1);

    // Test 5: sequence 1 with valid every other cycle; invalid cycles carry loud junk
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send(300, 1'b0);
      send(seq1[i], 1'b1);
      if (i == 2) check("t5_reg1_cnt", clap_cnt_o, 1);
      if (i == 4) check("t5_wait", state_o, ST_WAIT);
      if (i == 8) check("t5_reg2_cnt", clap_cnt_o, 2);
    end
    check("t5_fire_state", state_o, ST_FIRE);
    count_hold(1'b1, hi);
    check("t5_hold_len", hi, 4);
    check("t5_end_state", state_o, ST_IDLE);

    // Test 6: reset during the second FIRE cycle, then a fresh sequence
    do_reset();
    for (int i = 0; i < 11; i++) send(seq1[i], 1'b1);
    check("t6_fire1", state_o, ST_FIRE);
    send(0, 1'b1);
    check("t6_fire2_set", clap_set_o, 1);
    rst_i = 1'b1;
    send(0, 1'b1);
    rst_i = 1'b0;
    check("t6_rst_set", clap_set_o, 0);
    check("t6_rst_state", state_o, ST_IDLE);
    check("t6_rst_cnt", clap_cnt_o, 0);
    for (int i = 0; i < 11; i++) send(seq1[i], 1'b1);
    check("t6_refire_set", clap_set_o, 1);
    count_hold(1'b0, hi);
    check("t6_refire_hold", hi, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
